// File: rtl/tdp_arb_pkg.sv
// Shared types and defaults for the dual-port RAM arbiter.
package tdp_arb_pkg;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_DW    = 256;
    localparam int DEF_AW    = 4;
    localparam int DEF_DEPTH = 10;

    typedef enum logic {
        INIT,
        RUN
    } arb_state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/tdp_ram_arbiter_if.sv
// Requester-side bus: flattened per-requester request fields plus grant pulses.
interface tdp_ram_arbiter_if #(
    parameter int NREQ = 4,
    parameter int AW   = 4,
    parameter int DW   = 256
);
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      req_we;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_din;
    logic [NREQ-1:0]      gnt;

    modport master (
        output req, req_we, req_addr, req_din,
        input  gnt
    );

    modport slave (
        input  req, req_we, req_addr, req_din,
        output gnt
    );
endinterface

// File: rtl/tdp_rr_pick2.sv
// Round-robin picker: first requester from rr_ptr gets port A, the next
// requester that does not collide with A gets port B.
module tdp_rr_pick2 #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0]            req,
    input  logic [IDW-1:0]             rr_ptr,
    // coll[a][j] set when j may not share a cycle with a on the other port
    input  logic [NREQ-1:0][NREQ-1:0]  coll,
    output logic [IDW-1:0]             idx_a,
    output logic                       valid_a,
    output logic [IDW-1:0]             idx_b,
    output logic                       valid_b
);

    always_comb begin
        int j;
        // NOTE: every output gets a default before any branch, so no latch is inferred.
        idx_a   = '0;
        valid_a = 1'b0;
        idx_b   = '0;
        valid_b = 1'b0;
        j       = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NREQ) j -= NREQ;
            if (req[j]) begin
                if (!valid_a) begin
                    valid_a = 1'b1;
                    idx_a   = IDW'(j);
                end else if (!valid_b && !coll[idx_a][j]) begin
                    valid_b = 1'b1;
                    idx_b   = IDW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/tdp_ram_arbiter.sv
// Shares both ports of a true-dual-port RAM among NREQ requesters; zero-fills
// the RAM after reset, then grants up to two requests per cycle round-robin.
module tdp_ram_arbiter
    import tdp_arb_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int DW    = DEF_DW,
    parameter int AW    = DEF_AW,
    parameter int DEPTH = DEF_DEPTH,
    parameter int IDW   = clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    tdp_ram_arbiter_if.slave  bus,
    output logic              init_done,
    output logic              ram_weA,
    output logic              ram_weB,
    output logic [AW-1:0]     ram_addrA,
    output logic [AW-1:0]     ram_addrB,
    output logic [DW-1:0]     ram_dinA,
    output logic [DW-1:0]     ram_dinB,
    input  logic [DW-1:0]     ram_doutA,
    input  logic [DW-1:0]     ram_doutB,
    output logic              rsp_validA,
    output logic              rsp_validB,
    output logic [IDW-1:0]    rsp_idA,
    output logic [IDW-1:0]    rsp_idB,
    output logic [DW-1:0]     rsp_dataA,
    output logic [DW-1:0]     rsp_dataB,
    output logic              rsp_errA,
    output logic              rsp_errB
);

    localparam int INIT_CYCLES = (DEPTH + 1) / 2;

    arb_state_e           state, state_n;
    logic [AW-1:0]        cnt, cnt_n;
    logic [IDW-1:0]       rr_ptr, ptr_n;
    logic [AW-1:0]        addr_v [NREQ];
    logic [DW-1:0]        din_v  [NREQ];
    logic [NREQ-1:0][NREQ-1:0] coll;
    logic [IDW-1:0]       pa, pb;
    logic                 va, vb;
    logic                 rd_a, rd_b, err_a, err_b;
    int                   init_a;

    function automatic logic in_range(input logic [AW-1:0] a);
        return int'(a) < DEPTH;
    endfunction

    function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] i);
        return (int'(i) == NREQ - 1) ? '0 : IDW'(int'(i) + 1);
    endfunction

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign addr_v[i] = bus.req_addr[i*AW +: AW];
        assign din_v[i]  = bus.req_din[i*DW +: DW];
        // Two writes to one address never share a cycle; the later one waits.
        for (genvar j = 0; j < NREQ; j++) begin : g_coll
            assign coll[i][j] = bus.req_we[i] & bus.req_we[j] & (addr_v[i] == addr_v[j]);
        end
    end

    tdp_rr_pick2 #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req     (bus.req),
        .rr_ptr  (rr_ptr),
        .coll    (coll),
        .idx_a   (pa),
        .valid_a (va),
        .idx_b   (pb),
        .valid_b (vb)
    );

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        ptr_n     = rr_ptr;
        bus.gnt   = '0;
        ram_weA   = 1'b0;
        ram_weB   = 1'b0;
        ram_addrA = '0;
        ram_addrB = '0;
        ram_dinA  = '0;
        ram_dinB  = '0;
        rd_a      = 1'b0;
        rd_b      = 1'b0;
        err_a     = 1'b0;
        err_b     = 1'b0;
        init_a    = 2 * int'(cnt);

        unique case (state)
            INIT: begin
                ram_weA   = 1'b1;
                ram_addrA = AW'(init_a);
                ram_weB   = (init_a + 1) < DEPTH;
                ram_addrB = AW'(init_a + 1);
                if (int'(cnt) == INIT_CYCLES - 1) state_n = RUN;
                else                              cnt_n   = cnt + 1'b1;
            end
            RUN: begin
                if (va) begin
                    bus.gnt[pa] = 1'b1;
                    ram_addrA   = addr_v[pa];
                    ram_dinA    = din_v[pa];
                    ram_weA     = bus.req_we[pa] & in_range(addr_v[pa]);
                    rd_a        = ~bus.req_we[pa];
                    err_a       = ~in_range(addr_v[pa]);
                    ptr_n       = wrap_inc(pa);
                end
                if (vb) begin
                    bus.gnt[pb] = 1'b1;
                    ram_addrB   = addr_v[pb];
                    ram_dinB    = din_v[pb];
                    ram_weB     = bus.req_we[pb] & in_range(addr_v[pb]);
                    rd_b        = ~bus.req_we[pb];
                    err_b       = ~in_range(addr_v[pb]);
                    ptr_n       = wrap_inc(pb);
                end
            end
            default: state_n = INIT;
        endcase

        // Nothing reaches the RAM or the requesters while reset is held.
        if (rst) begin
            bus.gnt = '0;
            ram_weA = 1'b0;
            ram_weB = 1'b0;
            rd_a    = 1'b0;
            rd_b    = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments; the combinational block above uses blocking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= INIT;
            cnt        <= '0;
            rr_ptr     <= '0;
            init_done  <= 1'b0;
            rsp_validA <= 1'b0;
            rsp_validB <= 1'b0;
            rsp_idA    <= '0;
            rsp_idB    <= '0;
            rsp_errA   <= 1'b0;
            rsp_errB   <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            rr_ptr     <= ptr_n;
            init_done  <= (state_n == RUN);
            rsp_validA <= rd_a;
            rsp_validB <= rd_b;
            rsp_idA    <= rd_a ? pa : '0;
            rsp_idB    <= rd_b ? pb : '0;
            rsp_errA   <= rd_a & err_a;
            rsp_errB   <= rd_b & err_b;
        end
    end

    // The RAM presents data one cycle after the address, aligned with rsp_valid.
    assign rsp_dataA = (rsp_validA && !rsp_errA) ? ram_doutA : '0;
    assign rsp_dataB = (rsp_validB && !rsp_errB) ? ram_doutB : '0;

endmodule

// File: tb/tb_tdp_ram_arbiter.sv
// Bench for tdp_ram_arbiter: directed vector table, randomized traffic against a
// behavioural model, and a mid-run reset followed by a zero-fill readback.
module tb_tdp_ram_arbiter;

    localparam int NREQ  = 4;
    localparam int DW    = 256;
    localparam int AW    = 4;
    localparam int DEPTH = 10;
    localparam int IDW   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tdp_ram_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    logic            init_done;
    logic            ram_weA, ram_weB;
    logic [AW-1:0]   ram_addrA, ram_addrB;
    logic [DW-1:0]   ram_dinA, ram_dinB, ram_doutA, ram_doutB;
    logic            rsp_validA, rsp_validB, rsp_errA, rsp_errB;
    logic [IDW-1:0]  rsp_idA, rsp_idB;
    logic [DW-1:0]   rsp_dataA, rsp_dataB;

    tdp_ram_arbiter #(
        .NREQ(NREQ), .DW(DW), .AW(AW), .DEPTH(DEPTH), .IDW(IDW)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .init_done(init_done),
        .ram_weA(ram_weA), .ram_weB(ram_weB),
        .ram_addrA(ram_addrA), .ram_addrB(ram_addrB),
        .ram_dinA(ram_dinA), .ram_dinB(ram_dinB),
        .ram_doutA(ram_doutA), .ram_doutB(ram_doutB),
        .rsp_validA(rsp_validA), .rsp_validB(rsp_validB),
        .rsp_idA(rsp_idA), .rsp_idB(rsp_idB),
        .rsp_dataA(rsp_dataA), .rsp_dataB(rsp_dataB),
        .rsp_errA(rsp_errA), .rsp_errB(rsp_errB)
    );

    // RAM with registered read address; starts full of junk so zero-fill is visible.
    logic [DW-1:0] ram_mem [16] = '{default: {8{32'hdeadbeef}}};
    logic [AW-1:0] ra_q = '0, rb_q = '0;
    always @(posedge clk) begin
        if (ram_weA) ram_mem[ram_addrA] <= ram_dinA;
        if (ram_weB) ram_mem[ram_addrB] <= ram_dinB;
        ra_q <= ram_addrA;
        rb_q <= ram_addrB;
    end
    assign ram_doutA = ram_mem[ra_q];
    assign ram_doutB = ram_mem[rb_q];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Stimulus state
    logic [NREQ-1:0] r_req, r_we;
    logic [AW-1:0]   r_addr [NREQ];
    logic [DW-1:0]   r_din  [NREQ];

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            bus.req[i]                = r_req[i];
            bus.req_we[i]             = r_we[i];
            bus.req_addr[i*AW +: AW]  = r_addr[i];
            bus.req_din[i*DW +: DW]   = r_din[i];
        end
    endtask

    task automatic idle();
        r_req = '0;
        r_we  = '0;
        for (int i = 0; i < NREQ; i++) begin
            r_addr[i] = '0;
            r_din[i]  = '0;
        end
        drive();
    endtask

    // Behavioural model: RAM contents, pointer, responses due next cycle
    int            m_ptr;
    logic [DW-1:0] m_mem [DEPTH];
    bit            e_rva, e_rvb, e_erra, e_errb;
    int            e_ida, e_idb;
    logic [DW-1:0] e_da, e_db;

    task automatic model_clear();
        m_ptr = 0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        e_rva = 1'b0;
        e_rvb = 1'b0;
    endtask

    task automatic check_rsp(input string p, input bit ev, input int eid, input bit eerr,
                             input logic [DW-1:0] ed, input logic v, input logic [IDW-1:0] id,
                             input logic err, input logic [DW-1:0] d);
        check({p, "_valid"}, DW'(v), DW'(ev));
        if (ev) begin
            check({p, "_id"}, DW'(id), DW'(eid));
            check({p, "_err"}, DW'(err), DW'(eerr));
            check({p, "_data"}, d, ed);
        end
    endtask

    task automatic check_port(input string p, input int idx, input logic we_act,
                              input logic [AW-1:0] ad_act, input logic [DW-1:0] d_act);
        if (idx < 0) begin
            check({p, "_we_idle"}, DW'(we_act), '0);
        end else begin
            check({p, "_addr"}, DW'(ad_act), DW'(r_addr[idx]));
            check({p, "_we"}, DW'(we_act), DW'(r_we[idx] && (int'(r_addr[idx]) < DEPTH)));
            if (r_we[idx]) check({p, "_din"}, d_act, r_din[idx]);
        end
    endtask

    task automatic next_rsp(input int idx, output bit v, output int id, output bit err,
                            output logic [DW-1:0] d);
        v = 1'b0; id = 0; err = 1'b0; d = '0;
        if (idx >= 0) begin
            if (!r_we[idx]) begin
                v  = 1'b1;
                id = idx;
                if (int'(r_addr[idx]) >= DEPTH) err = 1'b1;
                else                            d   = m_mem[r_addr[idx]];
            end
        end
    endtask

    // Evaluate one cycle from the driven inputs; optionally compare, always advance.
    task automatic model_eval(input bit chk, output int ia, output int ib);
        int              order[$];
        int              j, last;
        logic [NREQ-1:0] eg;
        ia = -1; ib = -1; eg = '0;
        if (chk) begin
            check_rsp("rspA", e_rva, e_ida, e_erra, e_da, rsp_validA, rsp_idA, rsp_errA, rsp_dataA);
            check_rsp("rspB", e_rvb, e_idb, e_errb, e_db, rsp_validB, rsp_idB, rsp_errB, rsp_dataB);
        end
        if (!rst) begin
            for (int k = 0; k < NREQ; k++) begin
                j = (m_ptr + k) % NREQ;
                if (r_req[j]) order.push_back(j);
            end
        end
        if (order.size() > 0) ia = order.pop_front();
        foreach (order[q]) begin
            if (ib < 0 && !(r_we[ia] && r_we[order[q]] && r_addr[ia] == r_addr[order[q]]))
                ib = order[q];
        end
        if (ia >= 0) eg[ia] = 1'b1;
        if (ib >= 0) eg[ib] = 1'b1;
        if (chk) begin
            check("gnt", DW'(bus.gnt), DW'(eg));
            check_port("portA", ia, ram_weA, ram_addrA, ram_dinA);
            check_port("portB", ib, ram_weB, ram_addrB, ram_dinB);
        end
        if (ia >= 0 && r_we[ia] && int'(r_addr[ia]) < DEPTH) m_mem[r_addr[ia]] = r_din[ia];
        if (ib >= 0 && r_we[ib] && int'(r_addr[ib]) < DEPTH) m_mem[r_addr[ib]] = r_din[ib];
        next_rsp(ia, e_rva, e_ida, e_erra, e_da);
        next_rsp(ib, e_rvb, e_idb, e_errb, e_db);
        last = (ib >= 0) ? ib : ia;
        if (last >= 0) m_ptr = (last + 1) % NREQ;
    endtask

    // Entered just after an edge that sampled rst=1; leaves the DUT in RUN.
    task automatic reset_init();
        idle();
        @(negedge clk);
        check("rst_gnt", DW'(bus.gnt), '0);
        check("rst_weA", DW'(ram_weA), '0);
        check("rst_weB", DW'(ram_weB), '0);
        check("rst_init_done", DW'(init_done), '0);
        check("rst_rsp_validA", DW'(rsp_validA), '0);
        check("rst_rsp_validB", DW'(rsp_validB), '0);
        check("rst_rsp_dataA", rsp_dataA, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < (DEPTH + 1) / 2; k++) begin
            @(negedge clk);
            check($sformatf("init%0d_weA", k), DW'(ram_weA), DW'(1'b1));
            check($sformatf("init%0d_addrA", k), DW'(ram_addrA), DW'(2 * k));
            check($sformatf("init%0d_dinA", k), ram_dinA, '0);
            check($sformatf("init%0d_weB", k), DW'(ram_weB), DW'((2 * k + 1) < DEPTH));
            check($sformatf("init%0d_addrB", k), DW'(ram_addrB), DW'(2 * k + 1));
            check($sformatf("init%0d_dinB", k), ram_dinB, '0);
            check($sformatf("init%0d_gnt", k), DW'(bus.gnt), '0);
            check($sformatf("init%0d_done", k), DW'(init_done), '0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("init_done_after", DW'(init_done), DW'(1'b1));
        @(posedge clk); #1;
        model_clear();
    endtask

    // Directed vector table
    typedef struct packed {
        logic [NREQ-1:0]      req;
        logic [NREQ-1:0]      we;
        logic [NREQ*AW-1:0]   addr;   // nibble i = requester i
        logic [NREQ*8-1:0]    din;    // byte i = requester i
        logic [NREQ-1:0]      e_gnt;
        logic                 e_wea, e_web;
        logic                 e_rva;
        logic [IDW-1:0]       e_ida;
        logic                 e_erra;
        logic [7:0]           e_da;
        logic                 e_rvb;
        logic [IDW-1:0]       e_idb;
        logic [7:0]           e_db;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] req, we, input logic [15:0] addr,
                                input logic [31:0] din, input logic [3:0] g,
                                input logic wa, wb, rva, input logic [1:0] ida,
                                input logic erra, input logic [7:0] da,
                                input logic rvb, input logic [1:0] idb, input logic [7:0] db);
        vec_t v;
        v = '{req, we, addr, din, g, wa, wb, rva, ida, erra, da, rvb, idb, db};
        return v;
    endfunction

    vec_t vecs [13];
    int   ia, ib;
    bit   pend [NREQ];

    initial begin
        vecs[0]  = mk(4'b0001, 4'b0001, 16'h0003, 32'h000000a5, 4'b0001, 1, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00);
        vecs[1]  = mk(4'b0100, 4'b0000, 16'h0300, 32'h0,        4'b0100, 0, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00);
        vecs[2]  = mk(4'b1000, 4'b0000, 16'hc000, 32'h0,        4'b1000, 0, 0, 1, 2, 0, 8'ha5, 0, 0, 8'h00);
        vecs[3]  = mk(4'b1111, 4'b0000, 16'h3210, 32'h0,        4'b0011, 0, 0, 1, 3, 1, 8'h00, 0, 0, 8'h00);
        vecs[4]  = mk(4'b1111, 4'b0000, 16'h3210, 32'h0,        4'b1100, 0, 0, 1, 0, 0, 8'h00, 1, 1, 8'h00);
        vecs[5]  = mk(4'b1111, 4'b0000, 16'h3210, 32'h0,        4'b0011, 0, 0, 1, 2, 0, 8'h00, 1, 3, 8'ha5);
        vecs[6]  = mk(4'b1000, 4'b0000, 16'h4000, 32'h0,        4'b1000, 0, 0, 1, 0, 0, 8'h00, 1, 1, 8'h00);
        vecs[7]  = mk(4'b0110, 4'b0110, 16'h0550, 32'h00221100, 4'b0010, 1, 0, 1, 3, 0, 8'h00, 0, 0, 8'h00);
        vecs[8]  = mk(4'b0100, 4'b0100, 16'h0500, 32'h00220000, 4'b0100, 1, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00);
        vecs[9]  = mk(4'b0001, 4'b0000, 16'h0005, 32'h0,        4'b0001, 0, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00);
        vecs[10] = mk(4'b0110, 4'b0010, 16'h0770, 32'h00007700, 4'b0110, 1, 0, 1, 0, 0, 8'h22, 0, 0, 8'h00);
        vecs[11] = mk(4'b0001, 4'b0001, 16'h000d, 32'h00000099, 4'b0001, 0, 0, 0, 0, 0, 8'h00, 1, 2, 8'h77);
        vecs[12] = mk(4'b0000, 4'b0000, 16'h0000, 32'h0,        4'b0000, 0, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00);

        idle();
        model_clear();
        @(posedge clk); #1;
        reset_init();

        // Directed sequences
        for (int n = 0; n < 13; n++) begin
            r_req = vecs[n].req;
            r_we  = vecs[n].we;
            for (int i = 0; i < NREQ; i++) begin
                r_addr[i] = vecs[n].addr[i*AW +: AW];
                r_din[i]  = DW'(vecs[n].din[i*8 +: 8]);
            end
            drive();
            @(negedge clk);
            check($sformatf("v%0d_gnt", n), DW'(bus.gnt), DW'(vecs[n].e_gnt));
            check($sformatf("v%0d_weA", n), DW'(ram_weA), DW'(vecs[n].e_wea));
            check($sformatf("v%0d_weB", n), DW'(ram_weB), DW'(vecs[n].e_web));
            check_rsp($sformatf("v%0d_rspA", n), vecs[n].e_rva, int'(vecs[n].e_ida), vecs[n].e_erra,
                      DW'(vecs[n].e_da), rsp_validA, rsp_idA, rsp_errA, rsp_dataA);
            check_rsp($sformatf("v%0d_rspB", n), vecs[n].e_rvb, int'(vecs[n].e_idb), 1'b0,
                      DW'(vecs[n].e_db), rsp_validB, rsp_idB, rsp_errB, rsp_dataB);
            model_eval(1'b0, ia, ib);
            @(posedge clk); #1;
        end

        // Randomized traffic: requests are held until granted, occasionally withdrawn
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i]   = 1'b1;
                    r_we[i]   = ($urandom_range(0, 2) == 0);
                    r_addr[i] = ($urandom_range(0, 4) == 0) ? AW'($urandom_range(10, 15))
                                                            : AW'($urandom_range(0, 5));
                    for (int w = 0; w < DW / 32; w++) r_din[i][w*32 +: 32] = $urandom;
                end else if (pend[i] && $urandom_range(0, 15) == 0) begin
                    pend[i] = 1'b0;
                end
                r_req[i] = pend[i];
            end
            drive();
            @(negedge clk);
            model_eval(1'b1, ia, ib);
            if (ia >= 0) pend[ia] = 1'b0;
            if (ib >= 0) pend[ib] = 1'b0;
            @(posedge clk); #1;
        end

        // Reset while a read response is in flight
        idle();
        r_req[0]  = 1'b1;
        r_addr[0] = AW'(2);
        drive();
        @(negedge clk);
        model_eval(1'b1, ia, ib);
        @(posedge clk); #1;
        idle();
        rst = 1'b1;
        @(negedge clk);
        model_eval(1'b1, ia, ib);
        @(posedge clk); #1;
        reset_init();

        // Every address reads back zero after the second fill
        for (int a = 0; a < DEPTH / 2; a++) begin
            idle();
            r_req     = 4'b0011;
            r_addr[0] = AW'(2 * a);
            r_addr[1] = AW'(2 * a + 1);
            drive();
            @(negedge clk);
            model_eval(1'b1, ia, ib);
            @(posedge clk); #1;
        end
        idle();
        @(negedge clk);
        model_eval(1'b1, ia, ib);
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
